// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider family: FSM state encoding
// and default operand widths, kept here so signed/radix-4 variants can reuse them.
package seq_divider_pkg;

    localparam int N_WIDTH_DEF = 32;
    localparam int D_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int D_WIDTH = 16
) (
    input  logic [D_WIDTH-1:0] rem,
    input  logic               dividend_bit,
    input  logic [D_WIDTH-1:0] divisor,
    output logic [D_WIDTH-1:0] next_rem,
    output logic               quotient_bit
);

    logic [D_WIDTH:0] trial;

    assign trial        = {rem, dividend_bit};
    assign quotient_bit = (trial >= {1'b0, divisor});

    // Either branch fits in D_WIDTH bits: a failed trial is below the divisor,
    // a successful one leaves a remainder below the divisor.
    assign next_rem = quotient_bit ? D_WIDTH'(trial - {1'b0, divisor})
                                   : trial[D_WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// BUSY  | stepping through the dividend, MSB first
// DONE  | result held on the outputs until out_ready
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N_WIDTH = N_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               dbz
);

    localparam int CW = $clog2(N_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(N_WIDTH - 1);

    div_state_t         state;
    logic [CW-1:0]      count;
    logic [N_WIDTH-1:0] dq_sr;
    logic [D_WIDTH-1:0] prem;
    logic [D_WIDTH-1:0] dvsr;
    logic [D_WIDTH-1:0] next_rem;
    logic               qbit;

    div_step #(
        .D_WIDTH (D_WIDTH)
    ) u_step (
        .rem          (prem),
        .dividend_bit (dq_sr[N_WIDTH-1]),
        .divisor      (dvsr),
        .next_rem     (next_rem),
        .quotient_bit (qbit)
    );

    // dq_sr shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            dq_sr     <= '0;
            prem      <= '0;
            dvsr      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[D_WIDTH-1:0];
                            dbz       <= 1'b1;
                        end else begin
                            state <= BUSY;
                            dq_sr <= dividend;
                            dvsr  <= divisor;
                            prem  <= '0;
                            count <= '0;
                        end
                    end
                end
                BUSY: begin
                    dq_sr <= {dq_sr[N_WIDTH-2:0], qbit};
                    prem  <= next_rem;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state     <= DONE;
                        count     <= '0;
                        out_valid <= 1'b1;
                        quotient  <= {dq_sr[N_WIDTH-2:0], qbit};
                        remainder <= next_rem;
                        dbz       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operations compared against plain integer division.
module tb_seq_divider;

    localparam int NW = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          dbz;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_divider #(
        .N_WIDTH (NW),
        .D_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency as rising edges from the handshake
    // edge (inclusive) until out_valid is seen, hold off out_ready for 'hold'
    // cycles, then pop the result.
    task automatic run_op(input logic [NW-1:0] a, input logic [DW-1:0] b, input int hold,
                          input string tag, output logic [NW-1:0] got_q,
                          output logic [DW-1:0] got_r, output logic got_z);
        logic [NW-1:0] eq;
        logic [DW-1:0] er;
        logic          ez;
        int            elat;
        int            lat;
        if (b == '0) begin
            eq = '1; er = a[DW-1:0]; ez = 1'b1; elat = 1;
        end else begin
            eq = a / NW'(b); er = DW'(a % NW'(b)); ez = 1'b0; elat = NW + 1;
        end
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = DW'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " quotient"}, 64'(quotient), 64'(eq));
        check({tag, " remainder"}, 64'(remainder), 64'(er));
        check({tag, " dbz"}, 64'(dbz), 64'(ez));
        got_q = quotient;
        got_r = remainder;
        got_z = dbz;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = DW'($urandom);
            @(negedge clk);
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
            check({tag, " hold result"}, {quotient, remainder, 15'd0, dbz},
                  {eq, er, 15'd0, ez});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " popped"}, 64'(out_valid), 64'd0);
        check({tag, " ready again"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          z;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        int            flag_count;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("reset state", {quotient, remainder, 12'd0, in_ready, out_valid, 1'b0, dbz},
              {32'd0, 16'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        run_op(32'd100000, 16'd7, 0, "100000/7", q, r, z);
        run_op(32'hFFFF_FFFF, 16'hFFFF, 0, "max/max", q, r, z);
        run_op(32'd5, 16'd9, 0, "5/9", q, r, z);
        run_op(32'd1234, 16'd0, 0, "1234/0", q, r, z);
        run_op(32'hCAFE_F00D, 16'd1, 0, "div by 1", q, r, z);
        run_op(32'h0012_3456, 16'h0321, 10, "backpressure", q, r, z);
        run_op(32'd99, 16'd0, 3, "dbz backpressure", q, r, z);

        for (int i = 0; i < 20; i++) begin
            run_op($urandom, ($urandom_range(0, 5) == 0) ? 16'd0 : DW'($urandom),
                   $urandom_range(0, 3), "random", q, r, z);
        end

        // Abort an operation mid-flight with an asynchronous reset pulse.
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 16'h1234;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("mid-op busy", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("async reset", {quotient, remainder, 12'd0, in_ready, out_valid, 1'b0, dbz},
              {32'd0, 16'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd42, 16'd6, 0, "42/6 after reset", q, r, z);
        check("42/6 q", 64'(q), 64'd7);

        flag_count = 0;
        for (int i = 0; i < 8; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom_range(1, 65535));
            run_op(NW'(ra) * NW'(rb), rb, 0, "round trip", q, r, z);
            check("round trip q=a", 64'(q), 64'(ra));
            check("round trip r=0", 64'(r), 64'd0);
            if (z) flag_count++;
        end
        check("round trip dbz count", 64'(flag_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
